// File: rtl/arbitro_memoria.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Define ARB_PRIORIDADE_FIXA_EN for fixed port-0 priority instead of round-robin.
module arbitro_memoria #(
  parameter int bits = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req0,
  input  logic            req1,
  input  logic            we0,
  input  logic            we1,
  input  logic [bits-1:0] addr0,
  input  logic [bits-1:0] addr1,
  input  logic [bits-1:0] wdata0,
  input  logic [bits-1:0] wdata1,
  output logic            ack0,
  output logic            ack1,
  output logic [bits-1:0] rdata0,
  output logic [bits-1:0] rdata1,
  output logic            mem_write,
  output logic [bits-1:0] mem_endereco,
  output logic [bits-1:0] mem_dado_in,
  input  logic [bits-1:0] mem_dado_out,
  output logic            ocupado
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  estado_t         state_q;
  logic            sel_q;
  logic [bits-1:0] addr_q;
  logic [bits-1:0] wdata_q;
  logic            mw_q;
  logic            ocup_q;
  logic            ack0_q;
  logic            ack1_q;
  logic [bits-1:0] rdata0_q;
  logic [bits-1:0] rdata1_q;
  logic            gnt_sel_d;

`ifdef ARB_PRIORIDADE_FIXA_EN
  always_comb begin
    gnt_sel_d = req1 && !req0;
  end
`else
  logic ultimo_q;

  // On a tie the port that was not served last wins.
  always_comb begin
    gnt_sel_d = 1'b0;
    unique case (1'b1)
      req0 && req1:  gnt_sel_d = ~ultimo_q;
      req1 && !req0: gnt_sel_d = 1'b1;
      default:       gnt_sel_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ultimo_q <= 1'b1;
    end else if (state_q == ACESSO) begin
      ultimo_q <= sel_q;
    end
  end
`endif

  // mem_write is a register so reset clears it at once, killing the write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= OCIOSO;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mw_q     <= 1'b0;
      ocup_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        OCIOSO: begin
          if (req0 || req1) begin
            sel_q   <= gnt_sel_d;
            addr_q  <= gnt_sel_d ? addr1 : addr0;
            wdata_q <= gnt_sel_d ? wdata1 : wdata0;
            mw_q    <= gnt_sel_d ? we1 : we0;
            ocup_q  <= 1'b1;
            state_q <= ACESSO;
          end
        end
        ACESSO: begin
          mw_q <= 1'b0;
          if (sel_q) begin
            rdata1_q <= mem_dado_out;
            ack1_q   <= 1'b1;
          end else begin
            rdata0_q <= mem_dado_out;
            ack0_q   <= 1'b1;
          end
          state_q <= RESPOSTA;
        end
        RESPOSTA: begin
          ocup_q  <= 1'b0;
          state_q <= OCIOSO;
        end
        default: begin
          mw_q    <= 1'b0;
          ocup_q  <= 1'b0;
          state_q <= OCIOSO;
        end
      endcase
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign mem_write    = mw_q;
  assign mem_endereco = addr_q;
  assign mem_dado_in  = wdata_q;
  assign ocupado      = ocup_q;

endmodule
